// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state type and constants for the bit-serial adder
package serial_adder_pkg;

  // State encodings, kept as named constants so the enum and any debug
  // tooling agree on the raw values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Operand width used when the instantiator does not override it.
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_Adder.sv
// rtl/full_Adder.sv - combinational one-bit full adder cell
module full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder around a single full-adder cell
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only has to reach WIDTH, so it can never wrap.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  // The one and only adder cell: fed the current LSBs and the running carry.
  full_Adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (cnt == LAST_BIT);
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // Result register shifts right with the fresh sum bit entering at the MSB;
  // written per-bit so WIDTH=1 needs no zero-width slice.
  always_comb begin
    res_shift            = res_sr >> 1;
    res_shift[WIDTH-1]   = fa_sum;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DONE lasts one cycle, start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one bit per cycle, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_carry;
          res_sr <= res_shift;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= res_shift;
            cout <= fa_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
